muldiv_sched: RTL and testbench

//  Sequencer for the execute stage's shared multi-cycle units (multiplier, signed divider, unsigned divider).
//  - Accepts one MULT/DIV/REM/DIVU/REMU request from the execute stage and latches its operands.
//  - Launches exactly one unit, waits for that unit's data_ok, then returns a single result.
//  - Owns the pipeline stall, the divide-by-zero bypass, word-op operand/result extension,

---
 rtl/muldiv_sched_pkg.sv | 62 ++++++
 rtl/muldiv_sched_fixup.sv | 53 +++++
 rtl/muldiv_sched.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared types and helpers for the execute-stage mul/div sequencer.
// Op decode, unit mapping and word-result extension live here so every file agrees.
package muldiv_sched_pkg;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MULT,
        ALU_DIV,
        ALU_REM,
        ALU_DIVU,
        ALU_REMU
    } alufunc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    typedef enum logic [1:0] {
        U_MUL  = 2'd0,
        U_DIV  = 2'd1,
        U_DIVU = 2'd2
    } muldiv_unit_t;

    function automatic logic is_muldiv(input alufunc_t op);
        case (op)
            ALU_MULT, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU: is_muldiv = 1'b1;
            default:                                        is_muldiv = 1'b0;
        endcase
    endfunction

    function automatic muldiv_unit_t unit_of(input alufunc_t op);
        case (op)
            ALU_DIV, ALU_REM:   unit_of = U_DIV;
            ALU_DIVU, ALU_REMU: unit_of = U_DIVU;
            default:            unit_of = U_MUL;
        endcase
    endfunction

    function automatic logic is_rem(input alufunc_t op);
        case (op)
            ALU_REM, ALU_REMU: is_rem = 1'b1;
            default:           is_rem = 1'b0;
        endcase
    endfunction

    // W results are always sign-extended from bit 31, unsigned ops included.
    function automatic logic [63:0] w_ext(input logic word, input logic [63:0] r);
        w_ext = word ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

endpackage

// File: rtl/muldiv_sched_fixup.sv
// Combinational operand/result fixups for the mul/div sequencer:
// word-op operand extension, zero-divisor detect, bypass result and W result extension.
module muldiv_sched_fixup
    import muldiv_sched_pkg::*;
(
    input  alufunc_t    op,
    input  logic        word,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        res_word,
    input  logic [63:0] res_in,
    output logic [63:0] ext_a,
    output logic [63:0] ext_b,
    output logic        b_zero,
    output logic        div_class,
    output logic [63:0] byp_res,
    output logic [63:0] res_out
);

    // Operand extension: signed divides sign-extend, unsigned divides zero-extend, MULT untouched.
    always_comb begin
        ext_a = a;
        ext_b = b;
        if (word && is_muldiv(op)) begin
            case (unit_of(op))
                U_DIV: begin
                    ext_a = {{32{a[31]}}, a[31:0]};
                    ext_b = {{32{b[31]}}, b[31:0]};
                end
                U_DIVU: begin
                    ext_a = {32'd0, a[31:0]};
                    ext_b = {32'd0, b[31:0]};
                end
                default: begin
                    ext_a = a;
                    ext_b = b;
                end
            endcase
        end else begin
            ext_a = a;
            ext_b = b;
        end
    end

    // Zero-divisor bypass value and final W extension of unit results.
    always_comb begin
        b_zero    = (ext_b == 64'd0);
        div_class = is_muldiv(op) && (unit_of(op) != U_MUL);
        byp_res   = w_ext(word, is_rem(op) ? ext_a : {64{1'b1}});
        res_out   = w_ext(res_word, res_in);
    end

endmodule

// File: rtl/muldiv_sched.sv
// Sequencer for the shared multiplier / signed divider / unsigned divider.
// Claims one op, launches one unit, returns one result; handles stall, /0 bypass, flush and watchdog.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 128
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  alufunc_t    req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic        req_word,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] resp_result,
    output logic [63:0] unit_a,
    output logic [63:0] unit_b,
    output logic        mul_valid,
    output logic        div_valid,
    output logic        divu_valid,
    input  logic        mul_ok,
    input  logic        div_ok,
    input  logic        divu_ok,
    input  logic [63:0] mul_res,
    input  logic [63:0] div_quot,
    input  logic [63:0] div_rem,
    input  logic [63:0] divu_quot,
    input  logic [63:0] divu_rem,
    output logic        err_timeout
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT_CYCLES);

    muldiv_state_t state_r;
    muldiv_state_t state_nxt_s;
    alufunc_t      op_r;
    logic          word_r;
    muldiv_unit_t  unit_r;
    muldiv_unit_t  unit_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [63:0]   res_r;
    logic [63:0]   unit_a_r;
    logic [63:0]   unit_b_r;
    logic          err_r;
    logic          resp_valid_r;
    logic          mul_valid_r;
    logic          div_valid_r;
    logic          divu_valid_r;

    logic          claim_s;
    logic          accept_s;
    logic          unit_ok_s;
    logic          timeout_s;
    logic [63:0]   raw_res_s;
    logic [63:0]   fx_a_s;
    logic [63:0]   fx_b_s;
    logic          fx_zero_s;
    logic          fx_divcls_s;
    logic [63:0]   fx_byp_s;
    logic [63:0]   fx_res_s;

    muldiv_sched_fixup u_fixup (
        .op        (req_op),
        .word      (req_word),
        .a         (req_a),
        .b         (req_b),
        .res_word  (word_r),
        .res_in    (raw_res_s),
        .ext_a     (fx_a_s),
        .ext_b     (fx_b_s),
        .b_zero    (fx_zero_s),
        .div_class (fx_divcls_s),
        .byp_res   (fx_byp_s),
        .res_out   (fx_res_s)
    );

    assign claim_s   = req_valid && is_muldiv(req_op);
    assign accept_s  = claim_s && (state_r == IDLE) && !flush;
    assign timeout_s = (cnt_r == CNT_LAST);

    // Stall covers the claim cycle itself and releases in the response cycle.
    assign stall       = claim_s && (state_r != DONE);
    assign resp_valid  = resp_valid_r;
    assign resp_result = res_r;
    assign unit_a      = unit_a_r;
    assign unit_b      = unit_b_r;
    assign mul_valid   = mul_valid_r;
    assign div_valid   = div_valid_r;
    assign divu_valid  = divu_valid_r;
    assign err_timeout = err_r;

    // Next state, selected unit handshake and raw result select.
    always_comb begin
        state_nxt_s = state_r;
        unit_nxt_s  = accept_s ? unit_of(req_op) : unit_r;
        unit_ok_s   = 1'b0;
        raw_res_s   = 64'd0;
        case (unit_r)
            U_MUL:   unit_ok_s = mul_ok;
            U_DIV:   unit_ok_s = div_ok;
            U_DIVU:  unit_ok_s = divu_ok;
            default: unit_ok_s = 1'b0;
        endcase
        case (op_r)
            ALU_MULT: raw_res_s = mul_res;
            ALU_DIV:  raw_res_s = div_quot;
            ALU_REM:  raw_res_s = div_rem;
            ALU_DIVU: raw_res_s = divu_quot;
            ALU_REMU: raw_res_s = divu_rem;
            default:  raw_res_s = 64'd0;
        endcase
        // Flush wins over any same-cycle ok or claim.
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = (fx_zero_s && fx_divcls_s) ? DONE : BUSY;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                BUSY: begin
                    if (unit_ok_s || timeout_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/result latches, registered unit requests, watchdog counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r         <= ALU_ADD;
            word_r       <= 1'b0;
            unit_r       <= U_MUL;
            cnt_r        <= {CW{1'b0}};
            res_r        <= 64'd0;
            unit_a_r     <= 64'd0;
            unit_b_r     <= 64'd0;
            err_r        <= 1'b0;
            resp_valid_r <= 1'b0;
            mul_valid_r  <= 1'b0;
            div_valid_r  <= 1'b0;
            divu_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= (state_nxt_s == DONE);
            mul_valid_r  <= (state_nxt_s == BUSY) && (unit_nxt_s == U_MUL);
            div_valid_r  <= (state_nxt_s == BUSY) && (unit_nxt_s == U_DIV);
            divu_valid_r <= (state_nxt_s == BUSY) && (unit_nxt_s == U_DIVU);
            if (accept_s) begin
                op_r     <= req_op;
                word_r   <= req_word;
                unit_r   <= unit_of(req_op);
                unit_a_r <= fx_a_s;
                unit_b_r <= fx_b_s;
                res_r    <= fx_byp_s;
            end else if ((state_r == BUSY) && (state_nxt_s == DONE)) begin
                if (unit_ok_s) begin
                    res_r <= fx_res_s;
                end else begin
                    res_r <= 64'd0;
                    err_r <= 1'b1;
                end
            end
            // Counts BUSY cycles only; anything leaving BUSY restarts it from zero.
            if ((state_r == BUSY) && (state_nxt_s == BUSY)) begin
                cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: a timeline model of each transaction drives expected
// outputs, one negedge process compares them, and literal checks pin the headline cases.
`timescale 1ns/1ps
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_word, flush;
    alufunc_t    req_op;
    logic [63:0] req_a, req_b;
    logic        stall, resp_valid, mul_valid, div_valid, divu_valid, err_timeout;
    logic [63:0] resp_result, unit_a, unit_b;
    logic        mul_ok, div_ok, divu_ok;
    logic [63:0] mul_res, div_quot, div_rem, divu_quot, divu_rem;

    always #5 clk = ~clk;

    muldiv_sched #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_word(req_word), .flush(flush),
        .stall(stall), .resp_valid(resp_valid), .resp_result(resp_result),
        .unit_a(unit_a), .unit_b(unit_b), .mul_valid(mul_valid), .div_valid(div_valid),
        .divu_valid(divu_valid), .mul_ok(mul_ok), .div_ok(div_ok), .divu_ok(divu_ok),
        .mul_res(mul_res), .div_quot(div_quot), .div_rem(div_rem),
        .divu_quot(divu_quot), .divu_rem(divu_rem), .err_timeout(err_timeout)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_rv, exp_mv, exp_dv, exp_duv, exp_err, exp_ops;
    logic [63:0] exp_res, exp_ua, exp_ub;
    logic        err_sticky;
    int          rv_cnt, stall_cnt, uv_cnt;
    logic [63:0] last_res, last_ua;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_ext(input alufunc_t op, input logic word, input logic [63:0] v);
        if (word && (op == ALU_DIV || op == ALU_REM)) return {{32{v[31]}}, v[31:0]};
        if (word && (op == ALU_DIVU || op == ALU_REMU)) return {32'd0, v[31:0]};
        return v;
    endfunction

    // Architectural result: RV64 M-extension semantics including divide-by-zero.
    function automatic logic [63:0] m_result(input alufunc_t op, input logic [63:0] a,
                                             input logic [63:0] b, input logic word);
        logic [63:0] ea, eb, r;
        ea = m_ext(op, word, a);
        eb = m_ext(op, word, b);
        case (op)
            ALU_MULT: r = ea * eb;
            ALU_DIV:  r = (eb == 64'd0) ? {64{1'b1}} : 64'($signed(ea) / $signed(eb));
            ALU_REM:  r = (eb == 64'd0) ? ea : 64'($signed(ea) % $signed(eb));
            ALU_DIVU: r = (eb == 64'd0) ? {64{1'b1}} : ea / eb;
            ALU_REMU: r = (eb == 64'd0) ? ea : ea % eb;
            default:  r = 64'd0;
        endcase
        return word ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    // Single compare process: every cycle while enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 64'(stall), 64'(exp_stall));
            chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
            chk("mul_valid", 64'(mul_valid), 64'(exp_mv));
            chk("div_valid", 64'(div_valid), 64'(exp_dv));
            chk("divu_valid", 64'(divu_valid), 64'(exp_duv));
            chk("err_timeout", 64'(err_timeout), 64'(exp_err));
            if (exp_rv) chk("resp_result", resp_result, exp_res);
            if (exp_ops) begin
                chk("unit_a", unit_a, exp_ua);
                chk("unit_b", unit_b, exp_ub);
            end
            if (resp_valid) begin
                rv_cnt++;
                last_res = resp_result;
            end
            if (stall) stall_cnt++;
            if (mul_valid || div_valid || divu_valid) begin
                uv_cnt++;
                last_ua = unit_a;
            end
        end
    end

    // One transaction. ok_at: BUSY cycle (1-based) with the unit's ok, 0 = never.
    // kill_at: cycle of flush/reset counted from the claim cycle, -1 = none.
    task automatic run_op(input alufunc_t op, input logic [63:0] a, input logic [63:0] b,
                          input logic word, input int ok_at, input int kill_at, input bit kill_rst);
        logic [63:0] ea, eb, er;
        bit md, byp, tmo, killed, live, is_busy, is_done;
        int end_busy, done_c, last;
        ea = m_ext(op, word, a);
        eb = m_ext(op, word, b);
        er = m_result(op, a, b, word);
        md = op inside {ALU_MULT, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU};
        byp = md && (op != ALU_MULT) && (eb == 64'd0);
        tmo = md && !byp && !(ok_at >= 1 && ok_at <= TO);
        end_busy = (ok_at >= 1 && ok_at <= TO) ? ok_at : TO;
        done_c = byp ? 1 : end_busy + 1;
        killed = (kill_at >= 0);
        last = killed ? kill_at + 1 : (md ? done_c + 1 : 1);
        rv_cnt = 0; stall_cnt = 0; uv_cnt = 0;
        last_res = 64'hDEAD_BEEF_DEAD_BEEF;
        last_ua = 64'hDEAD_BEEF_DEAD_BEEF;
        mul_res = ea * eb;
        div_quot = (eb == 64'd0) ? 64'd0 : 64'($signed(ea) / $signed(eb));
        div_rem = (eb == 64'd0) ? 64'd0 : 64'($signed(ea) % $signed(eb));
        divu_quot = (eb == 64'd0) ? 64'd0 : ea / eb;
        divu_rem = (eb == 64'd0) ? 64'd0 : ea % eb;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            live = !(killed && c > kill_at);
            is_busy = md && !byp && live && c >= 1 && c <= end_busy;
            is_done = md && live && c == done_c;
            reset = killed && kill_rst && c == kill_at;
            flush = killed && !kill_rst && c == kill_at;
            req_valid = live && !reset && (md ? c <= done_c : c == 0);
            req_op = op; req_a = a; req_b = b; req_word = word;
            mul_ok = (c == ok_at) && (op == ALU_MULT);
            div_ok = (c == ok_at) && (op == ALU_DIV || op == ALU_REM);
            divu_ok = (c == ok_at) && (op == ALU_DIVU || op == ALU_REMU);
            if (is_done && tmo) err_sticky = 1'b1;
            if (killed && kill_rst && c == kill_at + 1) err_sticky = 1'b0;
            exp_stall = req_valid && md && !is_done;
            exp_mv = is_busy && op == ALU_MULT;
            exp_dv = is_busy && (op == ALU_DIV || op == ALU_REM);
            exp_duv = is_busy && (op == ALU_DIVU || op == ALU_REMU);
            exp_rv = is_done;
            exp_res = tmo ? 64'd0 : er;
            exp_err = err_sticky;
            exp_ops = is_busy;
            exp_ua = ea;
            exp_ub = eb;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_word = 1'b0; flush = 1'b0; req_op = ALU_ADD;
        req_a = 64'd0; req_b = 64'd0; mul_ok = 1'b0; div_ok = 1'b0; divu_ok = 1'b0;
        mul_res = 64'd0; div_quot = 64'd0; div_rem = 64'd0; divu_quot = 64'd0; divu_rem = 64'd0;
        exp_stall = 1'b0; exp_rv = 1'b0; exp_mv = 1'b0; exp_dv = 1'b0; exp_duv = 1'b0;
        exp_err = 1'b0; exp_ops = 1'b0; exp_res = 64'd0; exp_ua = 64'd0; exp_ub = 64'd0;
        err_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_resp_result", resp_result, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        chk("model_mult", m_result(ALU_MULT, 64'd3, 64'd5, 1'b0), 64'd15);
        chk("model_divw", m_result(ALU_DIV, 64'h0000_0000_8000_0000, 64'd1, 1'b1), 64'hFFFF_FFFF_8000_0000);
        chk("model_rem0", m_result(ALU_REM, 64'd7, 64'd0, 1'b0), 64'd7);
        chk("model_remneg", m_result(ALU_REM, -64'sd7, 64'd2, 1'b0), {64{1'b1}});

        run_op(ALU_MULT, 64'd3, 64'd5, 1'b0, 4, -1, 1'b0);
        chk("mult_result", last_res, 64'd15);
        chk("mult_stall_cycles", 64'(stall_cnt), 64'd5);
        chk("mult_resp_cycles", 64'(rv_cnt), 64'd1);

        run_op(ALU_DIV, 64'd7, 64'd0, 1'b0, 0, -1, 1'b0);
        chk("div0_result", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div0_no_unit", 64'(uv_cnt), 64'd0);
        run_op(ALU_REM, 64'd7, 64'd0, 1'b0, 0, -1, 1'b0);
        chk("rem0_result", last_res, 64'd7);

        run_op(ALU_DIV, 64'h0000_0000_8000_0000, 64'd1, 1'b1, 2, -1, 1'b0);
        chk("divw_unit_a", last_ua, 64'hFFFF_FFFF_8000_0000);
        chk("divw_result", last_res, 64'hFFFF_FFFF_8000_0000);

        run_op(ALU_DIVU, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 3, -1, 1'b0);
        chk("divuw_unit_a", last_ua, 64'h0000_0000_FFFF_FFFF);
        chk("divuw_result", last_res, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(ALU_DIVU, 64'd100, 64'd7, 1'b0, 4, 3, 1'b0);
        chk("flush_no_resp", 64'(rv_cnt), 64'd0);
        run_op(ALU_DIVU, 64'd100, 64'd7, 1'b0, 2, -1, 1'b0);
        chk("divu_result", last_res, 64'd14);
        run_op(ALU_REM, -64'sd7, 64'd2, 1'b0, 1, -1, 1'b0);
        chk("rem_neg_result", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(ALU_REMU, 64'd100, 64'd7, 1'b0, 7, -1, 1'b0);
        chk("remu_result", last_res, 64'd2);
        run_op(ALU_MULT, 64'h4000_0000, 64'd2, 1'b1, 1, -1, 1'b0);
        chk("mulw_result", last_res, 64'hFFFF_FFFF_8000_0000);
        run_op(ALU_DIV, 64'd5, 64'h0000_0001_0000_0000, 1'b1, 0, -1, 1'b0);
        chk("divw_hi_zero", last_res, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(ALU_ADD, 64'd1, 64'd2, 1'b0, 0, -1, 1'b0);
        chk("add_no_stall", 64'(stall_cnt), 64'd0);

        run_op(ALU_DIV, 64'd100, 64'd7, 1'b0, 0, -1, 1'b0);
        chk("timeout_result", last_res, 64'd0);
        chk("timeout_resp_cycles", 64'(rv_cnt), 64'd1);
        chk("timeout_err", 64'(err_timeout), 64'd1);
        run_op(ALU_MULT, 64'd2, 64'd3, 1'b0, 2, -1, 1'b0);
        chk("err_sticky", 64'(err_timeout), 64'd1);
        chk("after_timeout_result", last_res, 64'd6);

        run_op(ALU_MULT, 64'd9, 64'd9, 1'b0, 0, 3, 1'b1);
        chk("reset_mid_no_resp", 64'(rv_cnt), 64'd0);
        chk("reset_clears_err", 64'(err_timeout), 64'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench time limit");
    end

endmodule
